ascon_round_iter: RTL and testbench
===================================

// Module: ascon_round_iter
// PURPOSE
//   Iterative Ascon permutation engine p^a / p^b. Generalises single-round constant addition:
//   - holds the 320-bit state in a register;
//   - sequences the round counter itself;
//   - per round, applies constant addition (pc), substitution layer (ps) and linear diffusion (pl);
//   - executes ROUNDS_PER_CYCLE rounds per clock.
//   Sits between the Ascon mode FSM (init/AD/text/final phases) and the state datapath.
// PARAMETERS
//   ROUNDS_PER_CYCLE  1  rounds unrolled per clock; legal values 1 or 2 (divides 6, 8 and 12);
//                        any other value is an elaboration error ($error)
// PORTS
//   clock_i     in   1    system clock, rising edge
//   resetb_i    in   1    synchronous reset, active low
//   start_i     in   1    request: load state_i and run nrounds_i rounds
//   nrounds_i   in   2    00: 12 rounds, 01: 8 rounds, 10: 6 rounds, 11: reserved (treated as 12)
//   state_i     in   320  type_state (5 x 64-bit lanes x0..x4), sampled with start_i
//   state_o     out  320  type_state, registered permutation state
//   round_o     out  4    index r (0..11) of the next round to execute; 12 when finished
//   busy_o      out  1    high while rounds are executing
//   done_o      out  1    one-cycle pulse: state_o holds the final result
// BEHAVIOUR
//   Reset (resetb_i=0 at an edge): state_o=0, round_o=0, busy_o=0, done_o=0, FSM->IDLE.
//     Reset wins over every other input, including mid-run; the run is discarded.
//   FSM states:
//     IDLE -> RUN on start_i: state reg <= state_i; r <= 12-N (N = 12/8/6).
//     RUN  -> each edge: applies ROUNDS_PER_CYCLE rounds; r <= r + ROUNDS_PER_CYCLE.
//     RUN  -> DONE when r reaches 12 at that edge.
//     DONE -> IDLE after exactly one cycle.
//     DONE -> RUN directly if start_i is high in DONE (back-to-back); done_o still pulses for that cycle.
//   start_i while in RUN is ignored: no reload, no restart.
//   Latency: start sampled at edge T0; result registered at edge T0 + N/ROUNDS_PER_CYCLE.
//     done_o=1 and busy_o=0 in the cycle following that edge.
//   busy_o=1 exactly in RUN cycles. state_o holds its value in IDLE/DONE until the next start.
//   Round r, in order:
//     pc: x2 ^= {56'h0, c_r} with c_r = {4'hF - r[3:0], r[3:0]}
//         r=0 -> 8'hF0, r=4 -> 8'hB4, r=6 -> 8'h96, r=11 -> 8'h4B.
//     ps: 5-bit Ascon S-box applied bit-slice-wise across x0..x4 (bit i of each lane).
//     pl: xk ^= (xk >>> a) ^ (xk >>> b), rotate right, with (a,b):
//         x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
//   With ROUNDS_PER_CYCLE=2 the second round in the cycle uses c_(r+1).
//     The round function is a single combinational function instantiated twice.
//   round_o is the registered r.
//     Stays at 12 in DONE and after it, until the next start or reset.
//     Reset sets it to 0.
//   nrounds_i is sampled only with start_i; changes during RUN have no effect.
// TESTING
//   1. Reset mid-run: start N=12, then resetb_i=0 at the 3rd RUN edge
//      -> next cycle: state_o=0, busy_o=0, done_o=0, round_o=0; subsequent start runs normally.
//   2. Constant check (ROUNDS_PER_CYCLE=1): state x0..x4 =
//      80400c0600000000 / 0001020304050607 / 08090a0b0c0d0e0f / 0011223344556677 / 8899aabbccddeeff.
//      - N=12: round_o 0 -> 1 -> ... -> 12.
//      - Probe pc output: round 0 gives x2 = 08090a0b0c0d0eff; N=8 first c=B4; N=6 first c=96.
//   3. Latency: with the same state, N=12/8/6 -> done_o exactly 12/8/6 cycles after the start edge.
//      - busy_o high for exactly N cycles.
//      - state_o equals the golden Ascon C model p^12/p^8/p^6.
//   4. ROUNDS_PER_CYCLE=2, same vectors -> identical state_o.
//      - done_o after 6/4/3 cycles.
//      - round_o sequence 0, 2, ..., 12 for N=12.
//   5. start_i held high through the run (N=6) -> no restart.
//      - done_o pulses once at cycle 6.
//      - Second run starts from the DONE cycle; done_o again 6 cycles later.
//   6. nrounds_i=11 -> same result and latency as 00.
//      - nrounds_i toggled during RUN -> no effect on result.

Source files
------------

// File: rtl/ascon_round_iter.sv
// Iterative Ascon permutation p^a / p^b: holds the 320-bit state, sequences the
// round counter and applies ROUNDS_PER_CYCLE full rounds (pc, ps, pl) per clock.
module ascon_round_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [1:0]   nrounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
        $error("ascon_round_iter: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    localparam logic [3:0] STEP = 4'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e         fsm_q;
    logic [319:0] state_q, state_d;
    logic [3:0]   round_q, round_d, start_round;
    logic         busy_q, done_q;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One complete round; lane x0 occupies the most significant 64 bits.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'h0, 4'hF - r, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb begin
        state_d = ascon_round(state_q, round_q);
        if (ROUNDS_PER_CYCLE == 2) begin
            state_d = ascon_round(state_d, round_q + 4'd1);
        end
        round_d = round_q + STEP;
        case (nrounds_i)
            2'b01:   start_round = 4'd4;
            2'b10:   start_round = 4'd6;
            default: start_round = 4'd0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                RUN: begin
                    state_q <= state_d;
                    round_q <= round_d;
                    if (round_d == 4'd12) begin
                        fsm_q  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    // DONE accepts a new start directly so runs can go back to back.
                    if (start_i) begin
                        state_q <= state_i;
                        round_q <= start_round;
                        fsm_q   <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        fsm_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_round_iter.sv
// Scoreboard bench for ascon_round_iter: one instance per ROUNDS_PER_CYCLE value,
// expected results come from a table-driven reference permutation.
module tb_ascon_round_iter;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start1 = 1'b0, start2 = 1'b0;
    logic [1:0]   nrounds = 2'b00;
    logic [319:0] state_in = '0;

    logic [319:0] st1, st2;
    logic [3:0]   rnd1, rnd2;
    logic         busy1, busy2, done1, done2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bcnt1 = 0, bcnt2 = 0;

    typedef struct {
        logic [319:0] st;
        int           done_cyc;
        int           lat;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    localparam logic [319:0] V1 = {64'h80400c0600000000, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f, 64'h0011223344556677,
                                   64'h8899aabbccddeeff};
    localparam logic [319:0] V2 = '0;
    localparam logic [319:0] V3 = {64'hffffffffffffffff, 64'h0123456789abcdef,
                                   64'hdeadbeefcafef00d, 64'h5555aaaa5555aaaa,
                                   64'h0f0f0f0ff0f0f0f0};

    ascon_round_iter #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clock_i(clk), .resetb_i(rstn), .start_i(start1), .nrounds_i(nrounds),
        .state_i(state_in), .state_o(st1), .round_o(rnd1), .busy_o(busy1), .done_o(done1));

    ascon_round_iter #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clock_i(clk), .resetb_i(rstn), .start_i(start2), .nrounds_i(nrounds),
        .state_i(state_in), .state_o(st2), .round_o(rnd2), .busy_o(busy2), .done_o(done2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v};
        return d[n +: 64];
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  idx, o;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2] = x[2] ^ {56'h0, 4'(15 - r), 4'(r)};
            for (int i = 0; i < 64; i++) begin
                idx = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
                o = SBOX[idx];
                y[0][i] = o[4]; y[1][i] = o[3]; y[2][i] = o[2];
                y[3][i] = o[1]; y[4][i] = o[0];
            end
            x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
            x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
            x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
            x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
            x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!rstn) bcnt1 = 0;
        else begin
            if (busy1) bcnt1++;
            if (done1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL dut1_unexpected_done actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("dut1_state", st1, e.st);
                    chk("dut1_done_cycle", 320'(cyc), 320'(e.done_cyc));
                    chk("dut1_busy_cycles", 320'(bcnt1), 320'(e.lat));
                    chk("dut1_busy_in_done", 320'(busy1), 320'(0));
                end
                bcnt1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) bcnt2 = 0;
        else begin
            if (busy2) bcnt2++;
            if (done2) begin
                checks++;
                if (q2.size() == 0) begin
                    failures++;
                    $display("FAIL dut2_unexpected_done actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("dut2_state", st2, e.st);
                    chk("dut2_done_cycle", 320'(cyc), 320'(e.done_cyc));
                    chk("dut2_busy_cycles", 320'(bcnt2), 320'(e.lat));
                    chk("dut2_busy_in_done", 320'(busy2), 320'(0));
                end
                bcnt2 = 0;
            end
        end
    end

    function automatic int nr_to_n(input logic [1:0] nr);
        return (nr == 2'b01) ? 8 : (nr == 2'b10) ? 6 : 12;
    endfunction

    // Pulses start for one edge; returns at the negedge right after the start edge.
    task automatic issue(input logic [319:0] st, input logic [1:0] nr,
                         input bit s1, input bit s2, input bit push);
        exp_t e;
        int n;
        @(negedge clk);
        state_in = st; nrounds = nr; start1 = s1; start2 = s2;
        n = nr_to_n(nr);
        if (push) begin
            e.st = model_perm(st, n);
            if (s1) begin e.lat = n; e.done_cyc = cyc + 1 + n; q1.push_back(e); end
            if (s2) begin e.lat = n / 2; e.done_cyc = cyc + 1 + n / 2; q2.push_back(e); end
        end
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL queues_drained actual=%0d/%0d required=0/0", q1.size(), q2.size());
            q1.delete(); q2.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state1"}, st1, '0);
        chk({tag, "_round1"}, 320'(rnd1), 320'(0));
        chk({tag, "_busy1"}, 320'(busy1), 320'(0));
        chk({tag, "_done1"}, 320'(done1), 320'(0));
        chk({tag, "_state2"}, st2, '0);
        chk({tag, "_round2"}, 320'(rnd2), 320'(0));
        chk({tag, "_busy2"}, 320'(busy2), 320'(0));
        chk({tag, "_done2"}, 320'(done2), 320'(0));
    endtask

    initial begin
        exp_t e;
        int t0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;

        // Reset at the third RUN edge discards the run.
        issue(V1, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrun_reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // N=12 with round_o sequence on both instances.
        issue(V1, 2'b00, 1'b1, 1'b1, 1'b1);
        chk("seq12_round1_k0", 320'(rnd1), 320'(0));
        chk("seq12_round2_k0", 320'(rnd2), 320'(0));
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("seq12_round1_k%0d", k), 320'(rnd1), 320'((k > 12) ? 12 : k));
            chk($sformatf("seq12_round2_k%0d", k), 320'(rnd2), 320'((2*k > 12) ? 12 : 2*k));
        end
        wait_idle();
        chk("hold_state1", st1, model_perm(V1, 12));
        chk("hold_round1", 320'(rnd1), 320'(12));

        issue(V1, 2'b01, 1'b1, 1'b1, 1'b1);
        chk("n8_first_round1", 320'(rnd1), 320'(4));
        chk("n8_first_round2", 320'(rnd2), 320'(4));
        wait_idle();
        issue(V1, 2'b10, 1'b1, 1'b1, 1'b1);
        chk("n6_first_round1", 320'(rnd1), 320'(6));
        chk("n6_first_round2", 320'(rnd2), 320'(6));
        wait_idle();

        // Reserved code behaves as 12; later nrounds/start/state changes are ignored.
        issue(V3, 2'b11, 1'b1, 1'b1, 1'b1);
        nrounds = 2'b10; state_in = V2;
        @(negedge clk);
        start1 = 1'b1; start2 = 1'b1; nrounds = 2'b01;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        wait_idle();

        issue(V2, 2'b00, 1'b1, 1'b1, 1'b1);
        wait_idle();
        issue(V3, 2'b10, 1'b1, 1'b1, 1'b1);
        wait_idle();

        // Start held high through the run: one restart only from DONE.
        @(negedge clk);
        state_in = V1; nrounds = 2'b10; start1 = 1'b1;
        t0 = cyc + 1;
        e.st = model_perm(V1, 6); e.lat = 6;
        e.done_cyc = t0 + 6;  q1.push_back(e);
        e.done_cyc = t0 + 13; q1.push_back(e);
        repeat (9) @(negedge clk);
        start1 = 1'b0;
        wait_idle();

        @(negedge clk);
        state_in = V1; nrounds = 2'b10; start2 = 1'b1;
        t0 = cyc + 1;
        e.st = model_perm(V1, 6); e.lat = 3;
        e.done_cyc = t0 + 3; q2.push_back(e);
        e.done_cyc = t0 + 7; q2.push_back(e);
        repeat (5) @(negedge clk);
        start2 = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
